// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine beside the EX stage.
// Executes MULT/MULTU/DIV/DIVU in a fixed 34-cycle latency (start at T,
// done at T+34) using a 32-step shift-add multiplier and a restoring divider.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start        launch request, accepted only in IDLE or DONE
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA, opB     rs / rt operands
//   cancel       flush; aborts any in-flight operation, wins over start
//   busy         combinational stall request to the hazard unit
//   done         one-cycle pulse, hi/lo valid
//   hi, lo       product upper/lower word, or remainder/quotient
//   div_by_zero  set with done when a divide had opB == 0
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             sign_q;
  logic             sign_r;
  logic             b_zero_q;
  logic [WIDTH-1:0] opa_raw_q;
  logic [WIDTH-1:0] a_q;      // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0] acc_hi;   // upper product half (mult) or remainder (div)
  logic [WIDTH-1:0] acc_lo;   // multiplier/product low (mult) or dividend/quotient (div)

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state_nxt = S_CALC;
        S_CALC:  if (cnt == LAST_CNT) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // busy includes the issue cycle so EX stalls immediately; low in DONE.
  always_comb begin
    accept = start & ~cancel & ((state == S_IDLE) | (state == S_DONE));
    busy   = (state == S_CALC) | (state == S_FIX) | accept;
  end

  // ---------------- Operand conditioning at accept ----------------
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & opA[WIDTH-1];
    b_neg     = op_signed & opB[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - opA) : opA;
    b_mag     = b_neg ? (WIDTH'(0) - opB) : opB;
  end

  // ---------------- One iteration step ----------------
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  always_comb begin
    mul_addend = acc_lo[0] ? a_q : '0;
    mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    // Remainder shifted left with the next dividend bit; fits WIDTH+1 bits.
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, a_q};
    div_ge     = (div_shift >= {1'b0, a_q});
  end

  // ---------------- Sign correction / div-by-zero override ----------------
  logic [DW-1:0]    prod;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             fix_dbz;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = sign_q ? (DW'(0) - prod) : prod;
    fix_dbz  = 1'b0;
    if (!is_div_q) begin
      fix_hi = prod_fix[DW-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (b_zero_q) begin
      fix_hi  = opa_raw_q;
      fix_lo  = '1;
      fix_dbz = 1'b1;
    end else begin
      fix_hi = sign_r ? (WIDTH'(0) - acc_hi) : acc_hi;
      fix_lo = sign_q ? (WIDTH'(0) - acc_lo) : acc_lo;
    end
  end

  // ---------------- Datapath and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      is_div_q    <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      b_zero_q    <= 1'b0;
      opa_raw_q   <= '0;
      a_q         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt       <= '0;
        is_div_q  <= op[1];
        sign_q    <= a_neg ^ b_neg;
        sign_r    <= a_neg;
        b_zero_q  <= (opB == '0);
        opa_raw_q <= opA;
        a_q       <= op[1] ? b_mag : a_mag;
        acc_lo    <= op[1] ? a_mag : b_mag;
        acc_hi    <= '0;
      end else if (state == S_CALC) begin
        cnt <= cnt + CNT_W'(1);
        if (!is_div_q) begin
          // Carry of the add becomes the new top bit after the right shift.
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        end
      end else if ((state == S_FIX) && !cancel) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        div_by_zero <= fix_dbz;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: products, quotients, sign
// handling, divide-by-zero, cancel, reset mid-op and back-to-back issue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int vecs = 0;
  int errs = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request mid-cycle T; returns in cycle T+1 with start dropped.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; opA = a; opB = b; start = 1'b1;
    #1;
    chk("busy_issue", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle T+1; returns in the cycle where done is seen.
  task automatic wait_done(input string tag, output logic busy_ok);
    int lat;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd34);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                     input logic edbz);
    logic bok;
    issue(o, a, b);
    wait_done(tag, bok);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    logic bok;
    int   ndone;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);

    // MULTU max*max with busy window and done pulse width
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", bok);
    chk("multu_max_busy_window", 64'(bok), 64'd1);
    chk("multu_max_busy_done", 64'(busy), 64'd0);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);

    run("mult_neg3x7",  MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    run("multu_neg3x7", MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    run("div_neg7_2",   DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    run("div_min_m1",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    @(negedge clk);
    run("divu_by0",     DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    run("multu_5x6",    MULTU, 32'd5, 32'd6, 32'd0, 32'h1E, 1'b0);
    @(negedge clk);

    // Cancel at T+10 of DIVU 100/7
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_busy", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    chk("cancel_hi_hold", 64'(hi), 64'd0);
    chk("cancel_lo_hold", 64'(lo), 64'h1E);

    // Cancel and start together in IDLE: cancel wins
    op = DIVU; opA = 32'd9; opB = 32'd3; start = 1'b1; cancel = 1'b1;
    #1;
    chk("cancel_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("cancel_start_idle", 64'(busy), 64'd0);
    @(negedge clk);

    run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'hE, 1'b0);

    // Back-to-back: issue in the DONE cycle; a start during CALC is ignored
    chk("b2b_done_seen", 64'(done), 64'd1);
    issue(MULTU, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    op = DIV; opA = 32'd0; opB = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // Cycle count so far since issue: 1 + 5 + 1 + 2 = T+9
    begin
      int lat;
      lat = 9;
      while (done !== 1'b1 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_latency", 64'(lat), 64'd34);
    end
    chk("b2b_hi", 64'(hi), 64'd0);
    chk("b2b_lo", 64'(lo), 64'h1E);
    chk("b2b_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);

    // Reset at T+20 of a MULT
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the EX stage; executes MULT/MULTU/DIV/DIVU and produces the 64-bit {HI,LO} result that the WR stage commits to the HI/LO registers.
- Replaces the single-cycle 64-bit product path with a 32-step shift-add / restoring-divide engine.
- Exposes `busy` to the hazard logic so IF/ID/EX stall while an operation is in flight.
- Accepts a flush/cancel from branch, jump and CP0 redirects.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request from EX; sampled only when the engine can accept.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA  in  WIDTH  rs operand (forwarded value).
- opB  in  WIDTH  rt operand (forwarded value).
- cancel  in  1  flush; aborts any in-flight operation.
- busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  product upper word / remainder.
- lo  out  WIDTH  product lower word / quotient.
- div_by_zero  out  1  high with done when a DIV/DIVU had opB == 0.

Behaviour:
- Reset: state=IDLE, counter=0. Outputs: hi=0, lo=0, done=0, busy=0, div_by_zero=0.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 and cancel=0 while state is IDLE or DONE (cycle T).
  - Latch op.
  - Latch |opA| and |opB| for signed ops; raw values for unsigned ops.
  - Latch sign_q = opA[W-1]^opB[W-1] and sign_r = opA[W-1]. Both are 0 for unsigned ops.
  - Clear the accumulator and set counter=0.
  - Go to CALC at T+1.
- CALC: exactly WIDTH cycles (T+1..T+32); counter increments each cycle; leaves to FIX when counter==WIDTH-1.
  - Mult: if the multiplier LSB is set, add the multiplicand to the upper accumulator half (WIDTH+1-bit add, carry kept); shift the 2*WIDTH accumulator right by 1.
  - Div: shift {rem,quot} left by 1, trial-subtract the divisor from rem; if the result is non-negative, commit it and set the quotient LSB.
- FIX (T+33): apply sign correction and div-by-zero override, then register hi/lo; go to DONE.
  - Mult: if sign_q, negate the 64-bit product.
  - Div: if sign_q, negate the quotient; if sign_r, negate the remainder.
  - Div by zero: lo=all-ones, hi=original opA, div_by_zero=1. Same fixed latency as a normal divide.
- DONE (T+34): done=1 for exactly this cycle.
  - Leave to IDLE unless a new start is accepted this cycle.
  - hi/lo/div_by_zero hold until the FIX of the next completed operation.
- busy = (state==CALC) | (state==FIX) | (start & ~cancel & (state==IDLE | state==DONE)).
  - Combinational, so the EX instruction stalls on the issue cycle.
  - busy is low in the DONE cycle so the pipeline resumes.
- Fixed latency: start at T → done at T+34, for every op and every operand value.
- start while in CALC/FIX: ignored; no re-latch.
- cancel=1 in any state: next state IDLE, done stays 0, hi/lo/div_by_zero retain previous values. If cancel and start are asserted in the same cycle, cancel wins.
- rst mid-operation: identical to reset; hi/lo are cleared to 0.
- Signed 0x80000000 / -1: the natural unsigned magnitude gives lo=0x80000000, hi=0. No trap, no flag.
- Signed 0x80000000 as an operand: its magnitude 0x80000000 is handled as an unsigned WIDTH-bit value. No overflow handling is required.

Test Plan:
- MULTU opA=FFFFFFFF, opB=FFFFFFFF, start at T → busy 1 from T through T+33, done at T+34, hi=FFFFFFFE, lo=00000001.
- MULT opA=FFFFFFFD (-3), opB=00000007 → hi=FFFFFFFF, lo=FFFFFFEB at done; a MULTU of the same operands gives hi=00000006, lo=FFFFFFEB.
- DIV opA=FFFFFFF9 (-7), opB=00000002 → lo=FFFFFFFD, hi=FFFFFFFF, div_by_zero=0; DIV 0x80000000 / FFFFFFFF → lo=80000000, hi=00000000.
- DIVU opA=00000064, opB=0 → done at T+34, lo=FFFFFFFF, hi=00000064, div_by_zero=1; the next successful op clears div_by_zero.
- Run MULTU 5*6 to completion (hi=0, lo=1E), then start DIVU 100/7 and assert cancel at T+10 → busy=0 from T+11, no done pulse within 40 cycles, hi/lo stay 0/1E; re-issue DIVU 100/7 → lo=0000000E, hi=00000002.
- Assert rst at T+20 of a MULT → next cycle busy=0, hi=lo=0; start in DONE cycle (back-to-back ops) → second done exactly 34 cycles after second start, no idle gap required.
